// File: rtl/demo_release_pkg.sv
// demo_release_pkg: shared types and constants for the demo_release block.
//   state_e          - release-window FSM states
//   BLK_CNT_W        - width of the saturating blocked-cycle counter
//   DEFAULT_AUTH_KEY - code that opens the release window unless overridden
package demo_release_pkg;

    typedef enum logic [1:0] {
        StLocked  = 2'd0,
        StOpen    = 2'd1,
        StLockout = 2'd2
    } state_e;

    localparam int unsigned BLK_CNT_W = 8;

    localparam logic [31:0] DEFAULT_AUTH_KEY = 32'hA5A5_5A5A;

endpackage

// File: rtl/demo_release_fifo.sv
// demo_release_fifo: small synchronous FIFO, no bypass path.
// Ports:
//   clk, rst        - clock, async active-high reset (pointers only)
//   push, push_data - write push_data at the tail (caller ensures !full)
//   pop             - advance the head (caller ensures !empty)
//   full, empty     - occupancy flags
//   head            - entry at the head; undefined when empty
module demo_release_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty when indices match.
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the head is masked by the consumer while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= push_data;
    end

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        head  = mem[rptr_q[AW-1:0]];
    end

endmodule

// File: rtl/demo_release.sv
// demo_release: buffers tagged words and releases secret-derived (tainted) words
// only while an authorization window is open. Public words drain freely.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   in_valid, in_data, in_tainted  - upstream word and its taint bit
//   in_ready                       - FIFO can accept a word
//   auth_req, auth_code            - authorization attempt and presented code
//   out_valid, out_ready           - release handshake
//   out_data, out_tainted          - released word and taint, zero unless out_valid
//   win_open                       - release window currently open
//   blocked_cnt                    - saturating count of cycles a tainted head was held
module demo_release
    import demo_release_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WIDTH-1:0]  AUTH_KEY = WIDTH'(DEFAULT_AUTH_KEY),
    parameter int unsigned       WINDOW   = 8,
    parameter int unsigned       LOCKOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_tainted,
    output logic                 in_ready,
    input  logic                 auth_req,
    input  logic [WIDTH-1:0]     auth_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_tainted,
    output logic                 win_open,
    output logic [BLK_CNT_W-1:0] blocked_cnt
);

    localparam int unsigned CNT_MAX = (WINDOW > LOCKOUT) ? WINDOW : LOCKOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e               state_q, state_d;
    // One down-counter serves both the open window and the lockout penalty.
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BLK_CNT_W-1:0] blocked_q;

    logic                 fifo_full, fifo_empty;
    logic [WIDTH:0]       head_entry;
    logic                 head_tainted;
    logic                 head_ok;
    logic                 push, pop;

    demo_release_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_data, in_tainted}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLocked;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; auth_req is only honoured while locked.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StLocked: begin
                if (auth_req) begin
                    if (auth_code == AUTH_KEY) begin
                        state_d = StOpen;
                        cnt_d   = CNT_W'(WINDOW - 1);
                    end else begin
                        state_d = StLockout;
                        cnt_d   = CNT_W'(LOCKOUT - 1);
                    end
                end
            end
            StOpen, StLockout: begin
                if (cnt_q == '0) state_d = StLocked;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = StLocked;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: data and taint are forced to zero whenever the head is not releasable.
    always_comb begin
        win_open     = (state_q == StOpen);
        head_tainted = head_entry[0];
        head_ok      = !fifo_empty && (!head_tainted || win_open);
        out_valid    = head_ok;
        out_data     = head_ok ? head_entry[WIDTH:1] : '0;
        out_tainted  = head_ok ? head_tainted : 1'b0;
        // Pre-pop full flag: a full FIFO refuses a push even while popping.
        in_ready     = !fifo_full && !rst;
        push         = in_valid && in_ready;
        pop          = head_ok && out_ready;
        blocked_cnt  = blocked_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocked_q <= '0;
        end else if (!fifo_empty && head_tainted && !win_open &&
                     (blocked_q != {BLK_CNT_W{1'b1}})) begin
            blocked_q <= blocked_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_demo_release.sv
module tb_demo_release;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned WINDOW  = 8;
    localparam int unsigned LOCKOUT = 16;
    localparam logic [31:0] KEY     = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_tainted, in_ready;
    logic [31:0] in_data;
    logic        auth_req;
    logic [31:0] auth_code;
    logic        out_valid, out_ready, out_tainted, win_open;
    logic [31:0] out_data;
    logic [7:0]  blocked_cnt;

    always #5 clk = ~clk;

    demo_release #(
        .WIDTH    (32),
        .DEPTH    (DEPTH),
        .AUTH_KEY (KEY),
        .WINDOW   (WINDOW),
        .LOCKOUT  (LOCKOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_tainted  (in_tainted),
        .in_ready    (in_ready),
        .auth_req    (auth_req),
        .auth_code   (auth_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tainted (out_tainted),
        .win_open    (win_open),
        .blocked_cnt (blocked_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: a queue of {data, taint}, plus remaining open / lockout cycles.
    logic [32:0] mq[$];
    int          win_left, lock_left, blk;

    task automatic model_reset();
        mq.delete();
        win_left  = 0;
        lock_left = 0;
        blk       = 0;
    endtask

    function automatic bit model_hok();
        return (mq.size() > 0) && (!mq[0][0] || win_left > 0);
    endfunction

    task automatic model_check();
        bit          hok;
        logic [31:0] d;
        logic        t;
        hok = model_hok();
        d   = 32'h0;
        t   = 1'b0;
        if (hok) begin
            d = mq[0][32:1];
            t = mq[0][0];
        end
        chk("out_valid",   32'(out_valid),   32'(hok));
        chk("out_data",    out_data,         d);
        chk("out_tainted", 32'(out_tainted), 32'(t));
        chk("in_ready",    32'(in_ready),    32'(mq.size() < DEPTH));
        chk("win_open",    32'(win_open),    32'(win_left > 0));
        chk("blocked_cnt", 32'(blocked_cnt), 32'(blk));
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        bit hok, full;
        hok  = model_hok();
        full = mq.size() >= DEPTH;
        if (mq.size() > 0 && mq[0][0] && win_left == 0 && blk < 255) blk++;
        if (hok && out_ready) void'(mq.pop_front());
        if (in_valid && !full) mq.push_back({in_data, in_tainted});
        if (win_left > 0)       win_left--;
        else if (lock_left > 0) lock_left--;
        else if (auth_req) begin
            if (auth_code == KEY) win_left  = WINDOW;
            else                  lock_left = LOCKOUT;
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic it,
                         input logic ar, input logic [31:0] ac, input logic orr);
        in_valid   = iv;
        in_data    = id;
        in_tainted = it;
        auth_req   = ar;
        auth_code  = ac;
        out_ready  = orr;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic iv, input logic [31:0] id, input logic it,
                        input logic ar, input logic [31:0] ac, input logic orr);
        drive(iv, id, it, ar, ac, orr);
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic orr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, orr);
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        it;
        logic        ar;
        logic [31:0] ac;
        logic        orr;
        logic        ov;
        logic [31:0] od;
        logic        ot;
        logic        ir;
        logic        wo;
        logic [7:0]  bc;
    } vec_t;

    vec_t tab[$];

    function automatic void add(logic iv, logic [31:0] id, logic it, logic ar, logic [31:0] ac,
                                logic orr, logic ov, logic [31:0] od, logic ot, logic ir,
                                logic wo, logic [7:0] bc);
        vec_t v;
        v.iv = iv; v.id = id; v.it = it; v.ar = ar; v.ac = ac; v.orr = orr;
        v.ov = ov; v.od = od; v.ot = ot; v.ir = ir; v.wo = wo; v.bc = bc;
        tab.push_back(v);
    endfunction

    initial begin
        // Untainted flow: each word visible the cycle after its push.
        add(1, 32'h11, 0, 0, 0, 1,   0, 32'h0,  0, 1, 0, 0);
        add(1, 32'h22, 0, 0, 0, 1,   1, 32'h11, 0, 1, 0, 0);
        add(0, 32'h0,  0, 0, 0, 1,   1, 32'h22, 0, 1, 0, 0);
        add(0, 32'h0,  0, 0, 0, 1,   0, 32'h0,  0, 1, 0, 0);
        // Tainted word held while locked; blocked_cnt counts 10 held cycles.
        add(1, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 32'h0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0, 1, 0, 8'(i));
        // Correct code: window opens next cycle and the tainted word is released then.
        add(0, 32'h0, 0, 1, KEY, 1,  0, 32'h0, 0, 1, 0, 8'd10);
        add(0, 32'h0, 0, 0, 0,   1,  1, 32'hDEAD_BEEF, 1, 1, 1, 8'd11);
        for (int i = 0; i < 7; i++) add(0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0, 1, 1, 8'd11);
        add(0, 32'h0, 0, 0, 0, 1,    0, 32'h0, 0, 1, 0, 8'd11);

        // Reset state.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        #2;
        chk("rst_out_valid",   32'(out_valid),   32'h0);
        chk("rst_out_data",    out_data,         32'h0);
        chk("rst_out_tainted", 32'(out_tainted), 32'h0);
        chk("rst_in_ready",    32'(in_ready),    32'h0);
        chk("rst_win_open",    32'(win_open),    32'h0);
        chk("rst_blocked_cnt", 32'(blocked_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven directed vectors; model kept in step.
        foreach (tab[k]) begin
            drive(tab[k].iv, tab[k].id, tab[k].it, tab[k].ar, tab[k].ac, tab[k].orr);
            #1;
            chk($sformatf("tab%0d_out_valid", k),   32'(out_valid),   32'(tab[k].ov));
            chk($sformatf("tab%0d_out_data", k),    out_data,         tab[k].od);
            chk($sformatf("tab%0d_out_tainted", k), 32'(out_tainted), 32'(tab[k].ot));
            chk($sformatf("tab%0d_in_ready", k),    32'(in_ready),    32'(tab[k].ir));
            chk($sformatf("tab%0d_win_open", k),    32'(win_open),    32'(tab[k].wo));
            chk($sformatf("tab%0d_blocked_cnt", k), 32'(blocked_cnt), 32'(tab[k].bc));
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        // Wrong code: correct code during the lockout is ignored, accepted once locked again.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        idle(14, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, KEY, 1'b1);
        idle(1, 1'b1);
        #1 chk("lockout_ignores_key", 32'(win_open), 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, KEY, 1'b1);
        #1 chk("key_after_lockout", 32'(win_open), 32'h1);
        idle(WINDOW + 1, 1'b1);

        // Full / backpressure: fifth push refused, then pop-with-push while full.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
        #1 chk("full_in_ready", 32'(in_ready), 32'h0);
        step(1'b1, 32'h999, 1'b0, 1'b0, 32'h0, 1'b1);
        #1 chk("after_pop_in_ready", 32'(in_ready), 32'h1);
        idle(3, 1'b1);
        #1 chk("drained_after_three", 32'(out_valid), 32'h0);

        // Async reset mid-window with three tainted entries.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, KEY, 1'b0);
        idle(1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid",   32'(out_valid),   32'h0);
        chk("arst_out_data",    out_data,         32'h0);
        chk("arst_out_tainted", 32'(out_tainted), 32'h0);
        chk("arst_win_open",    32'(win_open),    32'h0);
        chk("arst_in_ready",    32'(in_ready),    32'h0);
        chk("arst_blocked_cnt", 32'(blocked_cnt), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(1, 1'b1);
        // A tainted word after reset must be held: window was discarded.
        step(1'b1, 32'h5EC2_E700, 1'b1, 1'b0, 32'h0, 1'b1);
        idle(2, 1'b1);

        // Saturation of blocked_cnt.
        idle(300, 1'b1);
        #1 chk("blocked_saturates", 32'(blocked_cnt), 32'd255);
        step(1'b0, 32'h0, 1'b0, 1'b1, KEY, 1'b1);
        idle(WINDOW + 1, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        iv, it, ar, orr;
            logic [31:0] id, ac;
            iv  = ($urandom % 2) == 0;
            id  = $urandom;
            it  = ($urandom % 3) == 0;
            ar  = ($urandom % 12) == 0;
            ac  = (($urandom % 2) == 0) ? KEY : $urandom;
            orr = ($urandom % 4) != 0;
            step(iv, id, it, ar, ac, orr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
